onchip_ram_arbiter: RTL and testbench

ONCHIP_RAM_ARBITER -- requirements
Module: onchip_ram_arbiter

---
 rtl/onchip_ram_arbiter.sv | 137 +++++++++++++
 tb/tb_onchip_ram_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_ram_arbiter.sv
// Two-requester Avalon-MM arbiter in front of a single-port on-chip RAM.
// Round-robin grant, zero-wait commands, fixed two-cycle read latency.
module onchip_ram_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 7680
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_WORDS);

  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic any_gnt;
  logic last_grant;
  logic sel_read;
  logic sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic in_range;
  logic rd_issue;

  logic s1_valid;
  logic s1_owner;
  logic s1_oor;
  logic s2_valid;
  logic s2_owner;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // last_grant resets to 1 so m0 wins the first contention
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign any_gnt = gnt0 | gnt1;

  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;

  always_comb begin
    sel_addr       = m0_address;
    ram_byteenable = m0_byteenable;
    ram_writedata  = m0_writedata;
    sel_read       = m0_read;
    sel_write      = m0_write;
    if (gnt1) begin
      sel_addr       = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
      sel_read       = m1_read;
      sel_write      = m1_write;
    end
  end

  assign ram_address    = sel_addr;
  assign in_range       = {1'b0, sel_addr} < LIMIT;
  assign ram_chipselect = any_gnt & in_range;
  assign ram_write      = ram_chipselect & sel_write;
  assign ram_clken      = ~reset;

  // read+write together is a write: no response is queued
  assign rd_issue = any_gnt & sel_read & ~sel_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      s1_valid   <= 1'b0;
      s1_owner   <= 1'b0;
      s1_oor     <= 1'b0;
      s2_valid   <= 1'b0;
      s2_owner   <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      if (any_gnt) begin
        last_grant <= gnt1;
      end
      s1_valid <= rd_issue;
      s1_owner <= gnt1;
      s1_oor   <= ~in_range;
      s2_valid <= s1_valid;
      s2_owner <= s1_owner;
      if (s1_valid && !s1_owner) begin
        rdata0 <= s1_oor ? '0 : ram_readdata;
      end
      if (s1_valid && s1_owner) begin
        rdata1 <= s1_oor ? '0 : ram_readdata;
      end
    end
  end

  assign m0_readdatavalid = s2_valid & ~s2_owner;
  assign m1_readdatavalid = s2_valid & s2_owner;
  assign m0_readdata      = rdata0;
  assign m1_readdata      = rdata1;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed bench for onchip_ram_arbiter with a behavioural RAM,
// a grant model and a read-response scoreboard.
module tb_onchip_ram_arbiter;

  localparam int NW = 7680;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] m0_address;
  logic [3:0]  m0_byteenable;
  logic        m0_read;
  logic        m0_write;
  logic [31:0] m0_writedata;
  logic        m0_waitrequest;
  logic [31:0] m0_readdata;
  logic        m0_readdatavalid;
  logic [12:0] m1_address;
  logic [3:0]  m1_byteenable;
  logic        m1_read;
  logic        m1_write;
  logic [31:0] m1_writedata;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;
  logic        m1_readdatavalid;
  logic [12:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic        ram_clken;
  logic [31:0] ram_readdata;

  onchip_ram_arbiter dut (
    .clk(clk),
    .reset(rst),
    .m0_address(m0_address),
    .m0_byteenable(m0_byteenable),
    .m0_read(m0_read),
    .m0_write(m0_write),
    .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address),
    .m1_byteenable(m1_byteenable),
    .m1_read(m1_read),
    .m1_write(m1_write),
    .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address),
    .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect),
    .ram_write(ram_write),
    .ram_writedata(ram_writedata),
    .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, one-cycle read latency
  logic [31:0] ram_mem [0:NW-1];
  logic [31:0] wtmp;
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      ram_readdata <= ram_mem[ram_address];
      if (ram_write) begin
        wtmp = ram_mem[ram_address];
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) wtmp[8*b +: 8] = ram_writedata[8*b +: 8];
        ram_mem[ram_address] <= wtmp;
      end
    end
  end

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exp_mem [0:NW-1];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        lg = 1'b1;
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_rsp(input logic n, input logic [31:0] d);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_valid", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk("rd_owner", {31'b0, n}, {31'b0, e.owner});
      chk("rd_data", d, e.data);
      chk("rd_latency", cyc, e.due);
    end
  endtask

  always @(negedge clk) begin
    if (m0_readdatavalid || m1_readdatavalid) begin
      chk("dual_valid", {31'b0, m0_readdatavalid & m1_readdatavalid}, 32'd0);
      if (m0_readdatavalid) begin
        pop_rsp(1'b0, m0_readdata);
        last0 = m0_readdata;
      end
      if (m1_readdatavalid) begin
        pop_rsp(1'b1, m1_readdata);
        last1 = m1_readdata;
      end
    end
  end

  task automatic idle_cmds();
    m0_read = 0; m0_write = 0; m0_address = '0;
    m0_byteenable = 4'hF; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0;
    m1_byteenable = 4'hF; m1_writedata = '0;
  endtask

  task automatic cmd0(input logic r, input logic w, input logic [12:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    m0_read = r; m0_write = w; m0_address = a;
    m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic cmd1(input logic r, input logic w, input logic [12:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    m1_read = r; m1_write = w; m1_address = a;
    m1_byteenable = be; m1_writedata = d;
  endtask

  // One clock: predict grant, check handshake/RAM strobes, queue reads
  task automatic step();
    logic rq0, rq1, g0, g1, r, w, inr;
    logic [12:0] a;
    logic [3:0] be;
    logic [31:0] d, nw;
    exp_t e;
    @(negedge clk);
    rq0 = m0_read | m0_write;
    rq1 = m1_read | m1_write;
    g0 = 0;
    g1 = 0;
    if (!rst) begin
      if (rq0 && rq1) begin
        g0 = lg;
        g1 = ~lg;
      end else begin
        g0 = rq0;
        g1 = rq1;
      end
    end
    if (g1) begin
      r = m1_read; w = m1_write; a = m1_address;
      be = m1_byteenable; d = m1_writedata;
    end else begin
      r = m0_read; w = m0_write; a = m0_address;
      be = m0_byteenable; d = m0_writedata;
    end
    inr = (int'(a) < NW);
    chk("wait0", {31'b0, m0_waitrequest}, {31'b0, rq0 & ~g0});
    chk("wait1", {31'b0, m1_waitrequest}, {31'b0, rq1 & ~g1});
    chk("chipselect", {31'b0, ram_chipselect}, {31'b0, (g0 | g1) & inr});
    chk("ram_write", {31'b0, ram_write}, {31'b0, (g0 | g1) & inr & w});
    chk("clken", {31'b0, ram_clken}, {31'b0, ~rst});
    if ((g0 | g1) && w && inr) begin
      nw = exp_mem[a];
      for (int b = 0; b < 4; b++)
        if (be[b]) nw[8*b +: 8] = d[8*b +: 8];
      exp_mem[a] = nw;
    end
    if ((g0 | g1) && r && !w) begin
      e.owner = g1;
      e.data = inr ? exp_mem[a] : 32'h0;
      e.due = cyc + 2;
      q.push_back(e);
    end
    if (rst) begin
      lg = 1'b1;
      q.delete();
    end else if (g0 | g1) begin
      lg = g1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    idle_cmds();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      ram_mem[i] = i * 32'h9E37_79B1 + 32'h0F0F_0001;
      exp_mem[i] = i * 32'h9E37_79B1 + 32'h0F0F_0001;
    end
    ram_readdata = 32'hDEAD_BEEF;
    rst = 1;
    idle_cmds();
    @(posedge clk);
    #1;
    idle_steps(2);
    // requests during reset are never granted
    cmd0(1, 0, 13'h5, 4'hF, 0);
    cmd1(0, 1, 13'h6, 4'hF, 32'h1111_1111);
    step();
    chk("rst_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
    chk("rst_rd0", m0_readdata, 32'd0);
    chk("rst_rd1", m1_readdata, 32'd0);
    rst = 0;

    // contention from reset: m0, m1, m0, ...
    for (int i = 0; i < 8; i++) begin
      cmd0(1, 0, 13'(i), 4'hF, 0);
      cmd1(1, 0, 13'(100 + i), 4'hF, 0);
      step();
    end
    idle_steps(3);

    // write then read-after-write
    cmd0(0, 1, 13'h10, 4'hF, 32'h1234_5678);
    step();
    cmd0(1, 0, 13'h10, 4'hF, 0);
    step();
    idle_steps(3);

    // byte enables
    cmd1(0, 1, 13'h20, 4'hF, 32'hFFFF_FFFF);
    step();
    cmd1(0, 1, 13'h20, 4'h1, 32'h0000_00AA);
    step();
    cmd1(1, 0, 13'h20, 4'hF, 0);
    step();
    idle_steps(3);
    chk("be_merge", last1, 32'hFFFF_FFAA);

    // out-of-range write is dropped, read returns zero
    cmd1(0, 1, 13'd7680, 4'hF, 32'hCAFE_F00D);
    step();
    cmd1(1, 0, 13'd7680, 4'hF, 0);
    step();
    idle_steps(3);
    chk("oor_read", last1, 32'h0);

    // read+write together acts as a write only
    cmd0(1, 1, 13'h30, 4'hF, 32'h5555_AAAA);
    step();
    cmd0(1, 0, 13'h30, 4'hF, 0);
    step();
    idle_steps(3);

    // back-to-back reads, alternating owners, no contention
    idle_cmds();
    cmd0(1, 0, 13'h10, 4'hF, 0);
    step();
    idle_cmds();
    cmd1(1, 0, 13'h20, 4'hF, 0);
    step();
    idle_cmds();
    cmd0(1, 0, 13'h30, 4'hF, 0);
    step();
    idle_cmds();
    cmd1(1, 0, 13'h40, 4'hF, 0);
    step();
    idle_steps(4);
    chk("hold_rd0", m0_readdata, 32'h5555_AAAA);
    chk("hold_rd1", m1_readdata, exp_mem[13'h40]);

    // reset while a read is in flight
    cmd0(1, 0, 13'h10, 4'hF, 0);
    step();
    rst = 1;
    idle_steps(2);
    chk("rst_mid_rd0", m0_readdata, 32'd0);
    rst = 0;
    idle_steps(4);
    cmd0(1, 0, 13'h50, 4'hF, 0);
    cmd1(1, 0, 13'h60, 4'hF, 0);
    step();
    idle_steps(4);
    chk("first_contention_m0", last0, exp_mem[13'h50]);
    chk("queue_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
